// File: rtl/ser_pkg.sv
// Shared encodings and default widths for the MSB-first word serializer and its detector bench.
package ser_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LOAD  = 2'd2
    } state_t;

    localparam int DATA_W_DEF = 8;
    localparam int CNT_W_DEF  = 16;

endpackage

// File: rtl/ser_shift_reg.sv
// Load / shift-left register with MSB tap; load has priority over shift.
module ser_shift_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] din,
    output logic         msb
);

    logic [W-1:0] sreg;

    always_ff @(posedge clk) begin
        if (rst) begin
            sreg <= '0;
        end else if (load) begin
            sreg <= din;
        end else if (en) begin
            sreg <= {sreg[W-2:0], 1'b0};
        end
    end

    assign msb = sreg[W-1];

endmodule

// File: rtl/word_msb_serializer.sv
// Accepts DATA_W-bit words over valid/ready and shifts them out MSB-first with first/last framing.
// Optional SER_FRAME_CLR_EN adds a one-cycle LOAD state driving frame_clr before each word.
module word_msb_serializer
    import ser_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              ser_hold,
    output logic              ser_valid,
    output logic              ser_bit,
    output logic              ser_first,
    output logic              ser_last,
`ifdef SER_FRAME_CLR_EN
    output logic              frame_clr,
`endif
    output logic [CNT_W-1:0]  word_cnt
);

    localparam int               BIT_W    = $clog2(DATA_W);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

`ifdef SER_FRAME_CLR_EN
    localparam state_t ACCEPT_STATE = LOAD;
`else
    localparam state_t ACCEPT_STATE = SHIFT;
`endif

    // Handshake: a word moves when s_valid & s_ready at a rising edge; s_ready never looks at s_valid.
    state_t           state, state_nx;
    logic [BIT_W-1:0] bit_cnt, bit_cnt_nx;
    logic [CNT_W-1:0] word_cnt_nx;
    logic             load, shift_en, msb, is_last;

    ser_shift_reg #(.W(DATA_W)) u_shift (
        .clk  (clk),
        .rst  (rst),
        .load (load),
        .en   (shift_en),
        .din  (s_data),
        .msb  (msb)
    );

    assign is_last = (bit_cnt == LAST_BIT);
    assign ser_bit = (state == SHIFT) & msb;

    always_comb begin
        state_nx    = state;
        bit_cnt_nx  = bit_cnt;
        word_cnt_nx = word_cnt;
        load        = 1'b0;
        shift_en    = 1'b0;
        s_ready     = 1'b0;
        ser_valid   = 1'b0;
        ser_first   = 1'b0;
        ser_last    = 1'b0;
`ifdef SER_FRAME_CLR_EN
        frame_clr   = 1'b0;
`endif
        case (state)
            IDLE: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    load       = 1'b1;
                    bit_cnt_nx = '0;
                    state_nx   = ACCEPT_STATE;
                end
            end
`ifdef SER_FRAME_CLR_EN
            LOAD: begin
                frame_clr = 1'b1;
                state_nx  = SHIFT;
            end
`endif
            SHIFT: begin
                if (!ser_hold) begin
                    ser_valid = 1'b1;
                    ser_first = (bit_cnt == '0);
                    ser_last  = is_last;
                    if (is_last) begin
                        word_cnt_nx = word_cnt + CNT_W'(1);
                        s_ready     = 1'b1;
                        bit_cnt_nx  = '0;
                        // Zero-bubble reload when the next word is already waiting.
                        if (s_valid) begin
                            load     = 1'b1;
                            state_nx = ACCEPT_STATE;
                        end else begin
                            shift_en = 1'b1;
                            state_nx = IDLE;
                        end
                    end else begin
                        shift_en   = 1'b1;
                        bit_cnt_nx = bit_cnt + BIT_W'(1);
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            word_cnt <= '0;
        end else begin
            state    <= state_nx;
            bit_cnt  <= bit_cnt_nx;
            word_cnt <= word_cnt_nx;
        end
    end

endmodule

// File: tb/tb_word_msb_serializer.sv
// Directed bench for word_msb_serializer; builds with or without SER_FRAME_CLR_EN.
module tb_word_msb_serializer;

    localparam int DATA_W = 8;
`ifdef SER_FRAME_CLR_EN
    localparam int CNT_W = 4;
`else
    localparam int CNT_W = 16;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_data;
    logic              ser_hold;
    logic              ser_valid;
    logic              ser_bit;
    logic              ser_first;
    logic              ser_last;
`ifdef SER_FRAME_CLR_EN
    logic              frame_clr;
`endif
    logic [CNT_W-1:0]  word_cnt;

    int checks = 0;
    int errors = 0;
    int exp_words = 0;
    logic exp_q[$];

    always #5 clk = ~clk;

    word_msb_serializer #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .ser_hold  (ser_hold),
        .ser_valid (ser_valid),
        .ser_bit   (ser_bit),
        .ser_first (ser_first),
        .ser_last  (ser_last),
`ifdef SER_FRAME_CLR_EN
        .frame_clr (frame_clr),
`endif
        .word_cnt  (word_cnt)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [DATA_W-1:0] w);
        s_valid = 1'b1;
        s_data  = w;
        @(negedge clk);
        check_eq("accept_ready", 32'(s_ready), 32'd1);
        cyc();
        s_valid = 1'b0;
    endtask

    // Walks one accepted word bit by bit; hold_len stall cycles are inserted at bit hold_at.
    task automatic stream(input logic [DATA_W-1:0] w, input int hold_at, input int hold_len,
                          input int nbits);
        int   i      = 0;
        int   held   = 0;
        int   cycles = 0;
        int   res    = 0;
        logic h;
        logic b;
`ifdef SER_FRAME_CLR_EN
        @(negedge clk);
        check_eq("load_frame_clr", 32'(frame_clr), 32'd1);
        check_eq("load_no_valid", 32'(ser_valid), 32'd0);
        cyc();
`endif
        for (int k = DATA_W - 1; k >= 0; k--) exp_q.push_back(w[k]);
        while (i < nbits && cycles < 40) begin
            h = (i == hold_at) && (held < hold_len);
            ser_hold = h;
            @(negedge clk);
            if (h) begin
                check_eq("hold_valid", 32'(ser_valid), 32'd0);
                check_eq("hold_ready", 32'(s_ready), 32'd0);
                held++;
            end else begin
                b = exp_q.pop_front();
                check_eq("bit_valid", 32'(ser_valid), 32'd1);
                check_eq("bit_value", 32'(ser_bit), 32'(b));
                check_eq("bit_first", 32'(ser_first), 32'(i == 0));
                check_eq("bit_last", 32'(ser_last), 32'(i == DATA_W - 1));
                check_eq("bit_ready", 32'(s_ready), 32'(i == DATA_W - 1));
`ifdef SER_FRAME_CLR_EN
                check_eq("shift_frame_clr", 32'(frame_clr), 32'd0);
`endif
                res = (res * 2 + int'(ser_bit)) % 5;
                i++;
            end
            cyc();
            cycles++;
        end
        ser_hold = 1'b0;
        if (i < nbits) check_eq("stream_timeout", 32'(i), 32'(nbits));
        if (nbits == DATA_W) begin
            exp_words++;
            check_eq("residue", 32'(res), 32'(int'(w) % 5));
            check_eq("word_cycles", 32'(cycles), 32'(DATA_W + hold_len));
        end else begin
            exp_q.delete();
        end
    endtask

    initial begin
        rst      = 1'b1;
        s_valid  = 1'b1;
        s_data   = 8'hAA;
        ser_hold = 1'b0;

        // Reset with s_valid high must not accept anything.
        cyc();
        cyc();
        @(negedge clk);
        check_eq("rst_ready", 32'(s_ready), 32'd1);
        check_eq("rst_valid", 32'(ser_valid), 32'd0);
        check_eq("rst_word_cnt", 32'(word_cnt), 32'd0);
        rst     = 1'b0;
        s_valid = 1'b0;
        cyc();
        @(negedge clk);
        check_eq("post_rst_idle", 32'(ser_valid), 32'd0);
        cyc();

        // Single word 0x0A.
        accept(8'h0A);
        stream(8'h0A, -1, 0, DATA_W);
        @(negedge clk);
        check_eq("w0a_idle", 32'(ser_valid), 32'd0);
        check_eq("w0a_ready", 32'(s_ready), 32'd1);
        check_eq("w0a_cnt", 32'(word_cnt), 32'(exp_words));
        cyc();

        // Back-to-back 0xFF then 0x07 with s_valid held.
        accept(8'hFF);
        s_valid = 1'b1;
        s_data  = 8'h07;
        stream(8'hFF, -1, 0, DATA_W);
        s_valid = 1'b0;
        stream(8'h07, -1, 0, DATA_W);
        @(negedge clk);
        check_eq("b2b_cnt", 32'(word_cnt), 32'(exp_words));
        cyc();

        // Hold mid-word, then hold on the last bit.
        accept(8'hA5);
        stream(8'hA5, 4, 3, DATA_W);
        accept(8'h3C);
        stream(8'h3C, 7, 2, DATA_W);
        @(negedge clk);
        check_eq("hold_cnt", 32'(word_cnt), 32'(exp_words));
        cyc();

        // Hold while idle leaves s_ready up.
        ser_hold = 1'b1;
        @(negedge clk);
        check_eq("idle_hold_ready", 32'(s_ready), 32'd1);
        check_eq("idle_hold_valid", 32'(ser_valid), 32'd0);
        cyc();
        ser_hold = 1'b0;

        // Reset in the middle of a word drops it.
        accept(8'hC3);
        stream(8'hC3, -1, 0, 5);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        exp_words = 0;
        @(negedge clk);
        check_eq("midrst_valid", 32'(ser_valid), 32'd0);
        check_eq("midrst_ready", 32'(s_ready), 32'd1);
        check_eq("midrst_cnt", 32'(word_cnt), 32'd0);
        cyc();
        accept(8'h05);
        stream(8'h05, -1, 0, DATA_W);
        @(negedge clk);
        check_eq("after_rst_cnt", 32'(word_cnt), 32'(exp_words));
        cyc();

        // Sixteen more words: wraps a 4-bit counter back to 1, plain count otherwise.
        for (int n = 0; n < 16; n++) begin
            accept(8'h0A);
            stream(8'h0A, -1, 0, DATA_W);
        end
        @(negedge clk);
        check_eq("wrap_cnt", 32'(word_cnt), 32'(exp_words % (1 << CNT_W)));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
